// File: rtl/router_ingress_queue.sv
// router_ingress_queue
// Credit-controlled ingress FIFO in front of the 4-port combinational router.
// Words are accepted over a valid/ready handshake. The head word is dispatched
// only when its destination port holds a credit. Credits are returned per port
// by the downstream consumers.

module router_ingress_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CREDITS    = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [1:0]              s_addr,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [3:0]              credit_ret,
  output logic [DATA_WIDTH-1:0]   din,
  output logic                    din_en,
  output logic [1:0]              addr,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [3:0]       CREDIT_MAX = 4'(CREDITS);

  // Storage: payload and destination kept side by side per entry
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [1:0]            addr_mem [DEPTH];

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [3:0]            credit      [4];
  logic [3:0]            credit_next [4];
  logic [CNT_W-1:0]      count_next;

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_data;
  logic [1:0]            head_addr;

  // Ready depends only on registered occupancy; a pop in this cycle does not
  // free a slot until the following cycle
  assign s_ready = (count != FULL_COUNT);

  // Head lookup and the push/dispatch decisions, all from registered state
  always_comb begin
    head_data = data_mem[rd_ptr];
    head_addr = addr_mem[rd_ptr];
    push      = s_valid && s_ready;
    pop       = (count != '0) && (credit[head_addr] != 4'd0);
  end

  // Occupancy after this edge: a simultaneous push and pop cancel out
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Per-port credit update: dispatch consumes, return replenishes up to the
  // configured maximum, and both together leave the counter unchanged
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      credit_next[p] = credit[p];
      if (pop && (head_addr == 2'(p)) && !credit_ret[p]) begin
        credit_next[p] = credit[p] - 4'd1;
      end else if (!(pop && (head_addr == 2'(p))) && credit_ret[p] &&
                   (credit[p] < CREDIT_MAX)) begin
        credit_next[p] = credit[p] + 4'd1;
      end
    end
  end

  // Entry storage is written at the tail; contents need no reset because
  // occupancy alone decides which entries are meaningful
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= s_data;
      addr_mem[wr_ptr] <= s_addr;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // Credit counters start full and are restored to full by reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int p = 0; p < 4; p++) credit[p] <= CREDIT_MAX;
    end else begin
      for (int p = 0; p < 4; p++) credit[p] <= credit_next[p];
    end
  end

  // Router-facing outputs are registered and forced to zero between dispatches
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      din_en <= 1'b0;
      din    <= '0;
      addr   <= 2'd0;
    end else if (pop) begin
      din_en <= 1'b1;
      din    <= head_data;
      addr   <= head_addr;
    end else begin
      din_en <= 1'b0;
      din    <= '0;
      addr   <= 2'd0;
    end
  end

endmodule

// File: tb/tb_router_ingress_queue.sv
// Self-checking bench for router_ingress_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.

module tb_router_ingress_queue;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 4;
  localparam int CREDITS    = 2;

  logic                   clk;
  logic                   resetn;
  logic [DATA_WIDTH-1:0]  s_data;
  logic [1:0]             s_addr;
  logic                   s_valid;
  logic                   s_ready;
  logic [3:0]             credit_ret;
  logic [DATA_WIDTH-1:0]  din;
  logic                   din_en;
  logic [1:0]             addr;
  logic [$clog2(DEPTH):0] count;

  router_ingress_queue #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(DEPTH),
    .CREDITS(CREDITS)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .s_data(s_data),
    .s_addr(s_addr),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .credit_ret(credit_ret),
    .din(din),
    .din_en(din_en),
    .addr(addr),
    .count(count)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            port;
  } word_t;

  word_t                 model_q [$];
  int                    model_cred [4];
  logic                  exp_en;
  logic [DATA_WIDTH-1:0] exp_din;
  logic [1:0]            exp_addr;
  logic                  model_pushed;

  int check_count = 0;
  int error_count = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    for (int p = 0; p < 4; p++) model_cred[p] = CREDITS;
    exp_en   = 1'b0;
    exp_din  = '0;
    exp_addr = 2'd0;
    model_pushed = 1'b0;
  endtask

  // One clock edge of the reference: decide from the state before the edge,
  // then apply consumption, returns (saturating) and the new tail word
  task automatic modelStep(input logic v, input logic [DATA_WIDTH-1:0] d,
                           input logic [1:0] a, input logic [3:0] cr);
    bit    ready;
    bit    go;
    word_t head;
    word_t w;
    ready = (model_q.size() < DEPTH);
    go    = (model_q.size() > 0) && (model_cred[model_q[0].port] > 0);
    model_pushed = v && ready;
    if (go) begin
      head = model_q.pop_front();
      model_cred[head.port]--;
      exp_en   = 1'b1;
      exp_din  = head.data;
      exp_addr = head.port;
    end else begin
      exp_en   = 1'b0;
      exp_din  = '0;
      exp_addr = 2'd0;
    end
    for (int p = 0; p < 4; p++)
      if (cr[p] && model_cred[p] < CREDITS) model_cred[p]++;
    if (model_pushed) begin
      w.data = d;
      w.port = a;
      model_q.push_back(w);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, check ready before the
  // edge and the registered outputs just after it
  task automatic applyStimulus(input logic v, input logic [DATA_WIDTH-1:0] d,
                               input logic [1:0] a, input logic [3:0] cr);
    @(negedge clk);
    s_valid    = v;
    s_data     = d;
    s_addr     = a;
    credit_ret = cr;
    checkOutput("s_ready", 64'(s_ready), 64'(model_q.size() != DEPTH));
    modelStep(v, d, a, cr);
    @(posedge clk);
    #1;
    checkOutput("din_en", 64'(din_en), 64'(exp_en));
    checkOutput("din", 64'(din), 64'(exp_din));
    checkOutput("addr", 64'(addr), 64'(exp_addr));
    checkOutput("count", 64'(count), 64'(model_q.size()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 2'd0, 4'd0);
  endtask

  // Asynchronous reset between edges: outputs must clear without a clock
  task automatic applyReset();
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("rst_din_en", 64'(din_en), 64'd0);
    checkOutput("rst_din", 64'(din), 64'd0);
    checkOutput("rst_addr", 64'(addr), 64'd0);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_s_ready", 64'(s_ready), 64'd1);
    modelReset();
    s_valid    = 1'b0;
    s_data     = '0;
    s_addr     = 2'd0;
    credit_ret = 4'd0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    word_t feed [6];
    int    idx;
    resetn     = 1'b1;
    s_valid    = 1'b0;
    s_data     = '0;
    s_addr     = 2'd0;
    credit_ret = 4'd0;
    modelReset();
    #1;
    applyReset();

    // Basic latency: pushed at edge 0, on the router bus for cycle 1..2 only
    applyStimulus(1'b1, 32'hA5A5_0001, 2'd3, 4'd0);
    checkOutput("lat_edge0_en", 64'(din_en), 64'd0);
    idle(1);
    checkOutput("lat_en", 64'(din_en), 64'd1);
    checkOutput("lat_din", 64'(din), 64'hA5A5_0001);
    checkOutput("lat_addr", 64'(addr), 64'd3);
    idle(1);
    checkOutput("lat_clear_en", 64'(din_en), 64'd0);
    checkOutput("lat_clear_din", 64'(din), 64'd0);

    // Credit exhaustion on port 1, then a single return releases the third
    applyStimulus(1'b1, 32'h1111_0001, 2'd1, 4'd0);
    applyStimulus(1'b1, 32'h1111_0002, 2'd1, 4'd0);
    applyStimulus(1'b1, 32'h1111_0003, 2'd1, 4'd0);
    idle(3);
    checkOutput("exh_count", 64'(count), 64'd1);
    checkOutput("exh_hold", 64'(din_en), 64'd0);
    applyStimulus(1'b0, '0, 2'd0, 4'b0010);
    checkOutput("exh_ret_edge", 64'(din_en), 64'd0);
    idle(1);
    checkOutput("exh_release_en", 64'(din_en), 64'd1);
    checkOutput("exh_release_din", 64'(din), 64'h1111_0003);

    // Head-of-line blocking: starve port 0, then queue port 0 and port 2
    applyStimulus(1'b1, 32'h0000_00A0, 2'd0, 4'd0);
    applyStimulus(1'b1, 32'h0000_00A1, 2'd0, 4'd0);
    idle(2);
    applyStimulus(1'b1, 32'h0000_00B0, 2'd0, 4'd0);
    applyStimulus(1'b1, 32'h0000_00B2, 2'd2, 4'd0);
    idle(3);
    checkOutput("hol_blocked", 64'(din_en), 64'd0);
    checkOutput("hol_count", 64'(count), 64'd2);
    applyStimulus(1'b0, '0, 2'd0, 4'b0001);
    applyStimulus(1'b1, 32'h0000_00C3, 2'd3, 4'd0);
    checkOutput("hol_p0_first", 64'(din), 64'h0000_00B0);
    checkOutput("hol_pushpop_count", 64'(count), 64'd2);
    idle(1);
    checkOutput("hol_p2_next", 64'(din), 64'h0000_00B2);
    idle(3);

    // Reset while three words are queued and a dispatch is on the bus
    applyStimulus(1'b1, 32'h0000_0D00, 2'd0, 4'd0);
    applyStimulus(1'b1, 32'h0000_0D01, 2'd0, 4'd0);
    applyStimulus(1'b1, 32'h0000_0D02, 2'd0, 4'd0);
    applyStimulus(1'b1, 32'h0000_0D03, 2'd0, 4'b0001);
    idle(1);
    checkOutput("pre_rst_en", 64'(din_en), 64'd1);
    checkOutput("pre_rst_count", 64'(count), 64'd3);
    applyReset();
    applyStimulus(1'b1, 32'h2222_0001, 2'd2, 4'd0);
    applyStimulus(1'b1, 32'h2222_0002, 2'd2, 4'd0);
    checkOutput("post_rst_first", 64'(din), 64'h2222_0001);
    idle(1);
    checkOutput("post_rst_second", 64'(din), 64'h2222_0002);
    idle(1);

    // Drain every remaining credit so the queue can fill
    applyStimulus(1'b1, 32'h3, 2'd0, 4'd0);
    applyStimulus(1'b1, 32'h4, 2'd0, 4'd0);
    applyStimulus(1'b1, 32'h5, 2'd1, 4'd0);
    applyStimulus(1'b1, 32'h6, 2'd1, 4'd0);
    applyStimulus(1'b1, 32'h7, 2'd3, 4'd0);
    applyStimulus(1'b1, 32'h8, 2'd3, 4'd0);
    idle(3);

    // Full and wrap: six words offered with valid held high
    for (int i = 0; i < 6; i++) begin
      feed[i].data = 32'hF000_0000 | 32'(i);
      feed[i].port = 2'(i % 4);
    end
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, feed[idx].data, feed[idx].port, 4'd0);
      if (model_pushed && idx < 5) idx++;
    end
    checkOutput("full_count", 64'(count), 64'd4);
    checkOutput("full_ready", 64'(s_ready), 64'd0);
    for (int c = 0; c < 12 && idx < 6; c++) begin
      applyStimulus(1'b1, feed[idx].data, feed[idx].port,
                    (c < 2) ? 4'b1111 : 4'b0000);
      if (model_pushed) idx++;
    end
    idle(8);
    checkOutput("wrap_drained", 64'(count), 64'd0);

    // Saturation: extra returns must not lift port 2 above its maximum
    applyStimulus(1'b0, '0, 2'd0, 4'b1111);
    applyStimulus(1'b0, '0, 2'd0, 4'b1111);
    applyStimulus(1'b0, '0, 2'd0, 4'b1111);
    applyStimulus(1'b1, 32'h5A70_0001, 2'd2, 4'd0);
    applyStimulus(1'b1, 32'h5A70_0002, 2'd2, 4'd0);
    applyStimulus(1'b1, 32'h5A70_0003, 2'd2, 4'd0);
    idle(2);
    checkOutput("sat_count", 64'(count), 64'd1);
    applyStimulus(1'b0, '0, 2'd0, 4'b0100);
    idle(2);

    // Dispatch to port 3 and a port 3 return on the same edge
    applyStimulus(1'b1, 32'h3333_0001, 2'd3, 4'd0);
    applyStimulus(1'b0, '0, 2'd0, 4'b1000);
    checkOutput("sim_disp", 64'(din), 64'h3333_0001);
    applyStimulus(1'b1, 32'h3333_0002, 2'd3, 4'd0);
    applyStimulus(1'b1, 32'h3333_0003, 2'd3, 4'd0);
    applyStimulus(1'b1, 32'h3333_0004, 2'd3, 4'd0);
    idle(3);
    checkOutput("sim_hold_count", 64'(count), 64'd1);

    // Randomized traffic with sparse credit returns
    applyReset();
    for (int c = 0; c < 500; c++) begin
      applyStimulus(($urandom_range(0, 3) != 0), $urandom,
                    2'($urandom_range(0, 3)),
                    4'($urandom) & 4'($urandom));
    end
    for (int c = 0; c < 12; c++) applyStimulus(1'b0, '0, 2'd0, 4'b1111);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/router_ingress_queue.md
# router_ingress_queue

Credit-controlled ingress buffer that sits directly upstream of the 4-port combinational router. It accepts words with a 2-bit destination over a valid/ready handshake and stores them in a FIFO. It dispatches the head word to the router's `din`/`din_en`/`addr` inputs only when that destination port holds a credit. Per-port credits are returned by the downstream consumers, so a stalled port back-pressures the source instead of dropping data.

## Interface
- `DATA_WIDTH`, 32, payload width; matches the router's `DATA_WIDTH`.
- `DEPTH`, 4, number of FIFO entries; a power of two, ≥2.
- `CREDITS`, 2, initial and maximum credits per output port; 1..15.

- `clk`  in  1  the single clock; all state updates on its rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `s_data`  in  DATA_WIDTH  upstream payload.
- `s_addr`  in  2  upstream destination port (0..3).
- `s_valid`  in  1  upstream word valid.
- `s_ready`  out  1  queue can accept; `= (count != DEPTH)`.
- `credit_ret`  in  4  bit p pulses for one cycle to return one credit to port p.
- `din`  out  DATA_WIDTH  registered payload to the router; 0 when `din_en`=0.
- `din_en`  out  1  registered dispatch strobe, high for exactly one cycle per word.
- `addr`  out  2  registered destination to the router; 0 when `din_en`=0.
- `count`  out  $clog2(DEPTH)+1  registered FIFO occupancy, 0..DEPTH.

## Operation
- **Push.** A push occurs when `s_valid && s_ready` at a rising edge. `{s_data, s_addr}` is written at the tail, the write pointer increments modulo DEPTH, and `count` increments.
- **Dispatch.** Dispatch is legal when `count != 0` and `credit[head_addr] != 0`. Both are read from registered state; a `credit_ret` in the same cycle is not bypassed. On dispatch:
  - pop the head;
  - load `din`/`addr` from the head entry and set `din_en` = 1 at that edge;
  - decrement `credit[head_addr]`.
- **No dispatch.** With no dispatch, `din_en`, `din` and `addr` all register to 0.
- **Order.** Dispatch is strictly in order. A head word whose port has no credit blocks all later words (head-of-line blocking, by design).
- **Credit counters.** Each of the four counters is 4 bits wide and updates once per edge, per port p:
  - dispatch to p and `credit_ret[p]` together: unchanged;
  - dispatch only: −1;
  - return only: +1, saturating at CREDITS, so a return at CREDITS is ignored.
- **Simultaneous push and pop** is allowed whenever `s_ready`=1. `count` is then unchanged and both pointers advance.
- **Full.** When `count` = DEPTH, `s_ready`=0. There is no same-cycle pass-through on pop, so `s_ready` rises the cycle after the pop edge.
- **Empty.** A word pushed into an empty queue cannot dispatch at the same edge it is written.
- **Pointers** wrap modulo DEPTH. The extra `count` bit distinguishes full from empty.

## Timing
- **Reset.** While `resetn`=0, asynchronously:
  - `count`=0, `s_ready`=1;
  - `din`=0, `din_en`=0, `addr`=0;
  - pointers = 0, every credit = CREDITS.
  
  Reset mid-operation discards all queued words and in-flight credit state. The first edge after deassertion behaves as a fresh start.
- **Latency.** Let a word be accepted at edge k into an empty queue with credit available. It is dispatched at edge k+1, and `din_en`=1 during cycle k+1..k+2.
- **Throughput.** With continuous credit, sustained throughput is 1 word/cycle.
- **Credit stall.** For a head word stalled on credit, a `credit_ret` sampled at edge j makes the credit visible after j. Dispatch then occurs at edge j+1, giving one cycle of return-to-dispatch latency.
- **Outputs.** `din_en` is never high for two cycles on the same word. `din` and `addr` are 0 whenever `din_en`=0.

## Test plan
- **Reset values.** Assert `resetn`=0 mid-stream with 3 words queued.
  - Required: outputs go to 0 immediately, `count`=0, `s_ready`=1.
  - After release, a push to port 2 dispatches with full CREDITS (2 words to port 2 dispatch back-to-back without returns).
- **Basic latency.** Push 0xA5A5_0001 to addr 3 at edge 0.
  - Required: `din_en`=1, `din`=0xA5A5_0001, `addr`=3 in cycle 1..2; `din_en`=0, `din`=0 in cycle 2..3.
- **Credit exhaustion.** Push 3 words to port 1 with CREDITS=2 and no returns.
  - Required: 2 dispatches, then the third holds with `count`=1.
  - Pulse `credit_ret[1]` at edge j → third word has `din_en`=1 in cycle j+1..j+2.
- **Head-of-line blocking.** Port 0 has 0 credits. Push a word to port 0, then a word to port 2.
  - Required: no dispatch while port 0 is starved. After a `credit_ret[0]`, the port 0 word dispatches, then the port 2 word on the next edge.
- **Full/wrap.** DEPTH=4, all credits held at 0. Push 6 words with `s_valid` constantly high.
  - Required: `count` reaches 4, `s_ready`=0, exactly 4 accepted.
  - Restore credits → the 4 words emerge in order, pointers wrap, and the remaining 2 are accepted and emerge in order.
- **Credit saturation and simultaneous events.**
  - At CREDITS, pulse `credit_ret`=4'b1111 → counts stay at 2.
  - Dispatch to port 3 and `credit_ret[3]` on the same edge → port 3 credit unchanged.
  - Push and pop on the same edge at `count`=2 → `count` stays 2.
